// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared types and widths for the reorder buffer
package reorder_buffer_pkg;

    localparam int ROB_IDX_W_MAX = 6;
    localparam int REG_W         = 5;
    localparam int XLEN          = 32;

    typedef struct packed {
        logic [REG_W-1:0] dest_reg;
        logic             dest_reg_valid;
    } rob_alloc_t;

    typedef struct packed {
        logic [ROB_IDX_W_MAX-1:0] idx;
        logic [XLEN-1:0]          result_hi;
        logic [XLEN-1:0]          result_lo;
        logic                     valid;
    } rob_wb_t;

    typedef struct packed {
        logic             valid;
        logic             done;
        logic [REG_W-1:0] dest_reg;
        logic             dest_reg_valid;
        logic [XLEN-1:0]  result_hi;
        logic [XLEN-1:0]  result_lo;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - allocation, writeback, retire, flush and lookup signals of the reorder buffer
interface reorder_buffer_if
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 2,
    parameter int IDX_W  = $clog2(DEPTH)
);
    logic                     alloc_valid;
    logic [REG_W-1:0]         alloc_dest_reg;
    logic                     alloc_dest_reg_valid;
    logic                     alloc_ready;
    logic [IDX_W-1:0]         alloc_idx;

    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*IDX_W-1:0]  wb_idx;
    logic [NUM_WB*XLEN-1:0]   wb_result_lo;
    logic [NUM_WB*XLEN-1:0]   wb_result_hi;

    logic                     retire_valid;
    logic                     retire_ready;
    logic [IDX_W-1:0]         retire_idx;
    logic [REG_W-1:0]         retire_dest_reg;
    logic                     retire_dest_reg_valid;
    logic [XLEN-1:0]          retire_result_lo;
    logic [XLEN-1:0]          retire_result_hi;

    logic                     flush_valid;
    logic [IDX_W-1:0]         flush_idx;

    logic [REG_W-1:0]         lookup_reg;
    logic                     lookup_hit;
    logic [IDX_W-1:0]         lookup_idx;
    logic                     lookup_done;
    logic [XLEN-1:0]          lookup_data;

    modport master (
        output alloc_valid, alloc_dest_reg, alloc_dest_reg_valid,
        input  alloc_ready, alloc_idx,
        output wb_valid, wb_idx, wb_result_lo, wb_result_hi,
        input  retire_valid, retire_idx, retire_dest_reg, retire_dest_reg_valid,
        input  retire_result_lo, retire_result_hi,
        output retire_ready,
        output flush_valid, flush_idx,
        output lookup_reg,
        input  lookup_hit, lookup_idx, lookup_done, lookup_data
    );

    modport slave (
        input  alloc_valid, alloc_dest_reg, alloc_dest_reg_valid,
        output alloc_ready, alloc_idx,
        input  wb_valid, wb_idx, wb_result_lo, wb_result_hi,
        output retire_valid, retire_idx, retire_dest_reg, retire_dest_reg_valid,
        output retire_result_lo, retire_result_hi,
        input  retire_ready,
        input  flush_valid, flush_idx,
        input  lookup_reg,
        output lookup_hit, lookup_idx, lookup_done, lookup_data
    );

endinterface

// File: rtl/reorder_buffer_lookup.sv
// rtl/reorder_buffer_lookup.sv - youngest-first register match over the live entries, ordered from head
module reorder_buffer_lookup
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            valid_vec,
    input  logic [DEPTH-1:0]            dest_valid_vec,
    input  logic [DEPTH-1:0][REG_W-1:0] dest_vec,
    input  logic [IDX_W-1:0]            head,
    input  logic [REG_W-1:0]            lookup_reg,
    output logic                        hit,
    output logic [IDX_W-1:0]            idx
);

    logic [IDX_W-1:0] pos;

    // Walk oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head + IDX_W'(k);
            if ((lookup_reg != '0) && valid_vec[pos] && dest_valid_vec[pos] &&
                (dest_vec[pos] == lookup_reg)) begin
                hit = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with multi-port writeback, partial flush and operand lookup
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 2,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    reorder_buffer_if.slave   rob
);

    rob_entry_t        entries_q [DEPTH];
    rob_entry_t        entries_d [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    rob_alloc_t        alloc_s;
    rob_wb_t           wb_s [NUM_WB];
    logic              alloc_ready_c, retire_valid_c;
    logic              alloc_fire, retire_fire, flush_live;
    logic [IDX_W-1:0]  flush_off, off_i, wb_tgt;

    logic [DEPTH-1:0]            live_vec, dv_vec;
    logic [DEPTH-1:0][REG_W-1:0] dest_vec;
    logic                        lk_hit;
    logic [IDX_W-1:0]            lk_idx;

    always_comb begin
        for (int p = 0; p < NUM_WB; p++) begin
            wb_s[p].idx       = ROB_IDX_W_MAX'(rob.wb_idx[p*IDX_W +: IDX_W]);
            wb_s[p].result_hi = rob.wb_result_hi[p*XLEN +: XLEN];
            wb_s[p].result_lo = rob.wb_result_lo[p*XLEN +: XLEN];
            wb_s[p].valid     = rob.wb_valid[p];
        end
        for (int i = 0; i < DEPTH; i++) begin
            live_vec[i] = entries_q[i].valid;
            dv_vec[i]   = entries_q[i].dest_reg_valid;
            dest_vec[i] = entries_q[i].dest_reg;
        end
    end

    always_comb begin
        alloc_s        = '{dest_reg: rob.alloc_dest_reg, dest_reg_valid: rob.alloc_dest_reg_valid};
        alloc_ready_c  = count_q < (IDX_W+1)'(DEPTH);
        retire_valid_c = (count_q != '0) && entries_q[head_q].valid && entries_q[head_q].done;
        alloc_fire     = rob.alloc_valid && alloc_ready_c && !rob.flush_valid;
        retire_fire    = retire_valid_c && rob.retire_ready;
        flush_off      = rob.flush_idx - head_q;
        flush_live     = ({1'b0, flush_off} < count_q) && entries_q[rob.flush_idx].valid;
        entries_d      = entries_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        off_i          = '0;
        wb_tgt         = '0;

        // Ascending port order lets the highest-numbered port win a same-index collision.
        for (int p = 0; p < NUM_WB; p++) begin
            wb_tgt = wb_s[p].idx[IDX_W-1:0];
            if (wb_s[p].valid && ((wb_s[p].idx >> IDX_W) == '0) && entries_q[wb_tgt].valid) begin
                entries_d[wb_tgt].done      = 1'b1;
                entries_d[wb_tgt].result_hi = wb_s[p].result_hi;
                entries_d[wb_tgt].result_lo = wb_s[p].result_lo;
            end
        end

        if (alloc_fire) begin
            entries_d[tail_q] = '{valid: 1'b1, done: 1'b0,
                                  dest_reg: alloc_s.dest_reg,
                                  dest_reg_valid: alloc_s.dest_reg_valid,
                                  result_hi: '0, result_lo: '0};
            tail_d = tail_q + 1'b1;
        end

        if (retire_fire) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + 1'b1;
        end

        if (rob.flush_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                off_i = IDX_W'(i) - head_q;
                if (off_i > flush_off) begin
                    entries_d[i].valid = 1'b0;
                end
            end
            tail_d  = rob.flush_idx + 1'b1;
            count_d = {1'b0, flush_off} + (IDX_W+1)'(1) - {{IDX_W{1'b0}}, retire_fire};
        end else begin
            count_d = count_q + {{IDX_W{1'b0}}, alloc_fire} - {{IDX_W{1'b0}}, retire_fire};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    reorder_buffer_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lookup (
        .valid_vec      (live_vec),
        .dest_valid_vec (dv_vec),
        .dest_vec       (dest_vec),
        .head           (head_q),
        .lookup_reg     (rob.lookup_reg),
        .hit            (lk_hit),
        .idx            (lk_idx)
    );

    assign rob.alloc_ready           = alloc_ready_c;
    assign rob.alloc_idx             = tail_q;
    assign rob.retire_valid          = retire_valid_c;
    assign rob.retire_idx            = head_q;
    assign rob.retire_dest_reg       = entries_q[head_q].dest_reg;
    assign rob.retire_dest_reg_valid = entries_q[head_q].dest_reg_valid;
    assign rob.retire_result_lo      = entries_q[head_q].result_lo;
    assign rob.retire_result_hi      = entries_q[head_q].result_hi;
    assign rob.lookup_hit            = lk_hit;
    assign rob.lookup_idx            = lk_idx;
    assign rob.lookup_done           = lk_hit && entries_q[lk_idx].done;
    assign rob.lookup_data           = lk_hit ? entries_q[lk_idx].result_lo : '0;

    // A flush must name an entry that is currently in flight.
    flush_target_live: assert property (@(posedge clock) disable iff (!reset_n)
                                        rob.flush_valid |-> flush_live);

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized checks of reorder_buffer against a program-order queue model
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int NUM_WB = 2;
    localparam int IW     = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    reorder_buffer_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) rob_if ();

    reorder_buffer #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rob     (rob_if)
    );

    typedef struct {
        int          idx;
        logic [4:0]  dest;
        logic        dv;
        logic        done;
        logic [31:0] lo;
        logic [31:0] hi;
    } ment_t;

    ment_t q[$];
    int    m_head = 0;
    int    m_tail = 0;
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        rob_if.alloc_valid          = 1'b0;
        rob_if.alloc_dest_reg       = '0;
        rob_if.alloc_dest_reg_valid = 1'b0;
        rob_if.wb_valid             = '0;
        rob_if.wb_idx               = '0;
        rob_if.wb_result_lo         = '0;
        rob_if.wb_result_hi         = '0;
        rob_if.retire_ready         = 1'b0;
        rob_if.flush_valid          = 1'b0;
        rob_if.flush_idx            = '0;
        rob_if.lookup_reg           = '0;
    endtask

    task automatic set_alloc(input int dest, input logic dv);
        rob_if.alloc_valid          = 1'b1;
        rob_if.alloc_dest_reg       = 5'(dest);
        rob_if.alloc_dest_reg_valid = dv;
    endtask

    task automatic set_wb(input int p, input int idx, input logic [31:0] lo, input logic [31:0] hi);
        rob_if.wb_valid[p]               = 1'b1;
        rob_if.wb_idx[p*IW +: IW]        = idx[IW-1:0];
        rob_if.wb_result_lo[p*32 +: 32]  = lo;
        rob_if.wb_result_hi[p*32 +: 32]  = hi;
    endtask

    task automatic model_reset();
        q.delete();
        m_head = 0;
        m_tail = 0;
    endtask

    task automatic model_check();
        int   li;
        logic exp_rv;
        chk("alloc_ready", rob_if.alloc_ready, q.size() < DEPTH);
        chk("alloc_idx", rob_if.alloc_idx, m_tail);
        chk("count", dut.count_q, q.size());
        exp_rv = (q.size() > 0) && q[0].done;
        chk("retire_valid", rob_if.retire_valid, exp_rv);
        chk("retire_idx", rob_if.retire_idx, m_head);
        if (exp_rv) begin
            chk("retire_dest", rob_if.retire_dest_reg, q[0].dest);
            chk("retire_dv", rob_if.retire_dest_reg_valid, q[0].dv);
            chk("retire_lo", rob_if.retire_result_lo, q[0].lo);
            chk("retire_hi", rob_if.retire_result_hi, q[0].hi);
        end
        li = -1;
        if (rob_if.lookup_reg != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].dv && q[i].dest == rob_if.lookup_reg) begin
                    li = i;
                    break;
                end
            end
        end
        chk("lookup_hit", rob_if.lookup_hit, li >= 0);
        if (li >= 0) begin
            chk("lookup_idx", rob_if.lookup_idx, q[li].idx);
            chk("lookup_done", rob_if.lookup_done, q[li].done);
            if (q[li].done) chk("lookup_data", rob_if.lookup_data, q[li].lo);
        end else begin
            chk("lookup_idx_miss", rob_if.lookup_idx, 0);
            chk("lookup_done_miss", rob_if.lookup_done, 0);
            chk("lookup_data_miss", rob_if.lookup_data, 0);
        end
    endtask

    task automatic model_apply();
        logic  rfire, afire;
        int    k, wi;
        ment_t e;
        rfire = (q.size() > 0) && q[0].done && rob_if.retire_ready;
        afire = rob_if.alloc_valid && (q.size() < DEPTH) && !rob_if.flush_valid;
        for (int p = 0; p < NUM_WB; p++) begin
            if (rob_if.wb_valid[p]) begin
                wi = int'(rob_if.wb_idx[p*IW +: IW]);
                foreach (q[i]) begin
                    if (q[i].idx == wi) begin
                        q[i].done = 1'b1;
                        q[i].lo   = rob_if.wb_result_lo[p*32 +: 32];
                        q[i].hi   = rob_if.wb_result_hi[p*32 +: 32];
                    end
                end
            end
        end
        if (rob_if.flush_valid) begin
            k = -1;
            foreach (q[i]) if (q[i].idx == int'(rob_if.flush_idx)) k = i;
            if (k >= 0) q = q[0:k];
            m_tail = (int'(rob_if.flush_idx) + 1) % DEPTH;
        end else if (afire) begin
            e.idx  = m_tail;
            e.dest = rob_if.alloc_dest_reg;
            e.dv   = rob_if.alloc_dest_reg_valid;
            e.done = 1'b0;
            e.lo   = '0;
            e.hi   = '0;
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (rfire) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
    endtask

    task automatic step();
        #1;
        model_check();
        model_apply();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int k, wi;
        int lk_dests [7] = '{0, 1, 5, 3, 4, 7, 5};

        idle_in();
        rob_if.lookup_reg = 5'd1;
        reset_n = 1'b0;
        model_reset();
        #2;
        chk("rst_alloc_ready", rob_if.alloc_ready, 1);
        chk("rst_alloc_idx", rob_if.alloc_idx, 0);
        chk("rst_retire_valid", rob_if.retire_valid, 0);
        chk("rst_retire_lo", rob_if.retire_result_lo, 0);
        chk("rst_lookup_hit", rob_if.lookup_hit, 0);
        chk("rst_lookup_done", rob_if.lookup_done, 0);
        chk("rst_lookup_data", rob_if.lookup_data, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Fill all sixteen entries, then try one more.
        for (int i = 0; i < DEPTH; i++) begin
            idle_in();
            set_alloc(i + 1, 1'b1);
            step();
        end
        idle_in();
        set_alloc(20, 1'b1);
        #1;
        chk("full_alloc_ready", rob_if.alloc_ready, 0);
        chk("full_alloc_idx", rob_if.alloc_idx, 0);
        step();
        chk("full_count", dut.count_q, 16);

        // Out-of-order writeback holds retire until the head is done.
        idle_in(); set_wb(0, 1, 32'h101, 32'h1); step();
        idle_in(); #1; chk("ooo_rv_wait", rob_if.retire_valid, 0);
        set_wb(0, 0, 32'h100, 32'h0); step();
        idle_in(); rob_if.retire_ready = 1'b1; #1;
        chk("ret0_valid", rob_if.retire_valid, 1);
        chk("ret0_lo", rob_if.retire_result_lo, 32'h100);
        step();
        idle_in(); rob_if.retire_ready = 1'b1; #1;
        chk("ret1_lo", rob_if.retire_result_lo, 32'h101);
        chk("ret1_idx", rob_if.retire_idx, 1);
        step();

        // Same-index collision: port 1 wins.
        idle_in(); set_wb(0, 2, 32'h102, 32'h0); step();
        idle_in(); set_wb(0, 3, 32'hAAAA, 32'h0); set_wb(1, 3, 32'hBBBB, 32'h0); step();
        idle_in(); rob_if.retire_ready = 1'b1; step();
        idle_in(); rob_if.retire_ready = 1'b1; #1;
        chk("dual_wb_lo", rob_if.retire_result_lo, 32'hBBBB);
        chk("dual_wb_idx", rob_if.retire_idx, 3);
        step();

        // Youngest-match lookup.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            idle_in(); set_alloc(lk_dests[i], 1'b1); step();
        end
        idle_in(); rob_if.lookup_reg = 5'd5; #1;
        chk("lk_hit", rob_if.lookup_hit, 1);
        chk("lk_idx", rob_if.lookup_idx, 6);
        chk("lk_not_done", rob_if.lookup_done, 0);
        step();
        idle_in(); set_wb(0, 6, 32'h1234, 32'h0); step();
        idle_in(); rob_if.lookup_reg = 5'd5; #1;
        chk("lk_done", rob_if.lookup_done, 1);
        chk("lk_data", rob_if.lookup_data, 32'h1234);
        step();
        idle_in(); rob_if.lookup_reg = 5'd0; #1;
        chk("lk_r0_hit", rob_if.lookup_hit, 0);
        step();

        // Partial flush with a colliding allocation.
        idle_in(); set_wb(0, 0, 32'h10, 32'h0); set_wb(1, 1, 32'h11, 32'h0); step();
        idle_in(); rob_if.retire_ready = 1'b1; step();
        idle_in(); rob_if.retire_ready = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            idle_in(); set_alloc(8 + i, 1'b1); step();
        end
        idle_in(); #1;
        chk("pre_flush_tail", rob_if.alloc_idx, 10);
        chk("pre_flush_head", rob_if.retire_idx, 2);
        rob_if.flush_valid = 1'b1; rob_if.flush_idx = 4'd4; set_alloc(11, 1'b1);
        step();
        idle_in(); rob_if.lookup_reg = 5'd7; #1;
        chk("flush_tail", rob_if.alloc_idx, 5);
        chk("flush_count", dut.count_q, 3);
        chk("flush_lk7_hit", rob_if.lookup_hit, 0);
        step();

        // Flush while the head retires.
        for (int i = 0; i < 5; i++) begin
            idle_in(); set_alloc(12 + i, 1'b1); step();
        end
        idle_in(); set_wb(0, 2, 32'h22, 32'h2); step();
        idle_in(); rob_if.flush_valid = 1'b1; rob_if.flush_idx = 4'd4;
        rob_if.retire_ready = 1'b1; set_alloc(30, 1'b1); #1;
        chk("fr_rv", rob_if.retire_valid, 1);
        step();
        idle_in(); #1;
        chk("fr_count", dut.count_q, 2);
        chk("fr_tail", rob_if.alloc_idx, 5);
        chk("fr_head", rob_if.retire_idx, 3);
        step();

        // Asynchronous reset with seven live entries.
        for (int i = 0; i < 5; i++) begin
            idle_in(); set_alloc(17 + i, 1'b1); step();
        end
        idle_in(); set_wb(0, 3, 32'h33, 32'h3); step();
        idle_in(); rob_if.lookup_reg = 5'd4; #1;
        chk("pre_rst_count", dut.count_q, 7);
        chk("pre_rst_hit", rob_if.lookup_hit, 1);
        chk("pre_rst_rv", rob_if.retire_valid, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_alloc_ready", rob_if.alloc_ready, 1);
        chk("mid_rst_alloc_idx", rob_if.alloc_idx, 0);
        chk("mid_rst_retire_valid", rob_if.retire_valid, 0);
        chk("mid_rst_retire_lo", rob_if.retire_result_lo, 0);
        chk("mid_rst_lookup_hit", rob_if.lookup_hit, 0);
        chk("mid_rst_lookup_done", rob_if.lookup_done, 0);
        chk("mid_rst_lookup_data", rob_if.lookup_data, 0);
        chk("mid_rst_count", dut.count_q, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            idle_in();
            if ($urandom_range(0, 3) != 0) set_alloc(int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            for (int p = 0; p < NUM_WB; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    if (q.size() > 0 && $urandom_range(0, 9) < 7) wi = q[$urandom_range(0, q.size() - 1)].idx;
                    else wi = int'($urandom_range(0, DEPTH - 1));
                    set_wb(p, wi, $urandom, $urandom);
                end
            end
            rob_if.retire_ready = ($urandom_range(0, 2) != 0);
            rob_if.lookup_reg   = 5'($urandom_range(0, 7));
            if (q.size() > 0 && $urandom_range(0, 11) == 0) begin
                k = int'($urandom_range(0, q.size() - 1));
                rob_if.flush_valid = 1'b1;
                rob_if.flush_idx   = 4'(q[k].idx);
            end
            step();
        end

        idle_in();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Parametrised circular reorder buffer (ROB) holding in-flight instruction results between issue and register-file commit. It generalises the fixed 16-entry, single-writeback ROB to configurable depth and writeback-port count, and adds branch-recovery partial flush and a youngest-match operand lookup for forwarding. It sits between the decode/issue stage (allocation), the execution units (writeback) and the register file (retire).

Parameters:
DEPTH, 16, number of entries; power of two, minimum 4.
NUM_WB, 2, number of independent writeback ports.
IDX_W, $clog2(DEPTH), entry index width (derived; do not override).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
alloc_valid  in  1  allocate one entry this cycle
alloc_dest_reg  in  5  architectural destination register
alloc_dest_reg_valid  in  1  instruction writes a register
alloc_ready  out  1  entry available (count < DEPTH)
alloc_idx  out  IDX_W  index the next allocation receives (= tail)
wb_valid  in  NUM_WB  per-port writeback strobe
wb_idx  in  NUM_WB*IDX_W  per-port target entry
wb_result_lo  in  NUM_WB*32  per-port low result
wb_result_hi  in  NUM_WB*32  per-port high result (muldiv)
retire_valid  out  1  head entry allocated and written back
retire_ready  in  1  register file accepts head
retire_idx  out  IDX_W  head index
retire_dest_reg  out  5  head destination
retire_dest_reg_valid  out  1  head writes a register
retire_result_lo  out  32  head low result
retire_result_hi  out  32  head high result
flush_valid  in  1  discard all entries younger than flush_idx
flush_idx  in  IDX_W  last entry kept (branch delay slot)
lookup_reg  in  5  source register to search
lookup_hit  out  1  a live entry targets lookup_reg
lookup_idx  out  IDX_W  youngest matching entry
lookup_done  out  1  that entry is written back
lookup_data  out  32  its result_lo (valid only when lookup_done)

Behaviour:
- Reset (async, reset_n low): head=tail=0, count=0, all entry valid/done bits cleared. Outputs: alloc_ready=1, alloc_idx=0, retire_valid=0, lookup_hit=0, lookup_done=0; data outputs 0.
- State: head, tail (IDX_W, wrap modulo DEPTH), count (IDX_W+1 bits, range 0..DEPTH); per entry: valid, done, dest_reg, dest_reg_valid, result_hi, result_lo.
- Allocation fires on alloc_valid & alloc_ready: entry[tail] gets valid=1, done=0 and dest fields; tail++. When full, alloc_valid is ignored. alloc_ready depends only on registered count (no same-cycle retire bypass).
- Writeback: on wb_valid[p], if entry[wb_idx[p]].valid then set done=1 and store results; writes to invalid entries are dropped. When two ports hit the same index in one cycle, the higher port number wins. Results become visible to retire/lookup on the next cycle.
- Retire: retire_valid = count>0 & valid[head] & done[head]; all retire_* outputs are combinational from entry[head]. Fires on retire_valid & retire_ready: valid[head] cleared, head++.
- Count update: +1 on alloc fire, -1 on retire fire; both together leaves count unchanged.
- Flush: entries strictly younger than flush_idx are invalidated; tail := flush_idx+1; count := (flush_idx-head+1) minus 1 if retire fires that cycle. Flush overrides allocation in the same cycle (alloc ignored). Flush and retire of head in the same cycle are both honoured. flush_idx must name a live entry; any other value is a protocol violation (assertion).
- Lookup (combinational from registered state): search valid entries with dest_reg_valid & dest_reg==lookup_reg, youngest-first from tail-1 back to head. lookup_reg==0 never hits. On a miss, lookup_idx=0 and lookup_data=0.
- Wrap-around: head/tail wrap naturally; full vs empty is distinguished by count only.

Decomposition:
- pipTypes gains rob_alloc_t (dest_reg, dest_reg_valid) and rob_wb_t (idx, result_hi, result_lo, valid). Because the idx width is parametric, these use a package localparam ROB_IDX_W_MAX=6 and truncate to IDX_W.
- Existing rob_entry_t gets a done bit.
- Sub-module rob_lookup: a parametrised youngest-first priority search over the valid/dest vectors, rotated by head.

Test Plan:
- After reset, allocate 16 entries (dest r1..r16) -> alloc_ready=0 after the 16th; a 17th alloc_valid is ignored; count=16; alloc_idx wraps to 0.
- Write back idx 1 before idx 0 -> retire_valid stays 0 until idx 0 is done. Then retire_ready=1 retires idx0, then idx1, in consecutive cycles with correct result_lo.
- Both ports write idx 3 in the same cycle (port0 0xAAAA, port1 0xBBBB) -> retired result_lo=0xBBBB.
- Allocate r5 at idx 2 and r5 at idx 6 -> lookup_reg=5 gives hit=1, idx=6. After writeback 0x1234 to idx 6: done=1, data=0x1234. lookup_reg=0 -> hit=0.
- With head=2 and tail=10, flush_idx=4 while alloc_valid=1 -> next cycle tail=5 and count=3; entries 5..9 invalid; the allocation is dropped. With retire firing the same cycle -> count=2.
- Assert reset_n mid-stream with 7 entries live -> all outputs return to reset values immediately and count=0.
